// File: rtl/round_pack.sv
// Purpose: final float-add stage; rounds a normalized 27-bit fraction to nearest-even and packs an IEEE-754 single.
// Latency: 2 cycles from input transfer to out_valid, 1 result per cycle when out_ready stays high.
// Backpressure: valid/ready on both sides; at most 2 items in flight, in_ready drops when both stages are full and out_ready=0.
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   sign_in, fract_in, exp_in  normalized operand: fract_in = {hidden, mant[22:0], G, R, S}
//   out_valid / out_ready      downstream handshake
//   result                     packed {sign, exp[7:0], mant[22:0]}
//   flag_overflow/underflow/inexact  status, registered alongside result
module round_pack #(
    parameter int unsigned BIAS_MAX = 254
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [26:0] fract_in,
    input  logic [7:0]  exp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: round to nearest-even
    // ------------------------------------------------------------------
    logic        lsb;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [22:0] mant_rnd;
    logic        carry_rnd;

    assign lsb      = fract_in[3];
    assign guard    = fract_in[2];
    assign sticky   = fract_in[1] | fract_in[0];
    assign round_up = guard && (sticky || lsb);

    // The rounded 25-bit significand {carry, hidden, mant} is kept only as the
    // two pieces stage 2 needs. The mantissa increment wraps to zero exactly when
    // a carry out of the hidden bit occurs, which is the mantissa required in
    // that case anyway; the hidden bit itself is implied by the packed format.
    assign mant_rnd  = fract_in[25:3] + {22'd0, round_up};
    assign carry_rnd = fract_in[26] & (&fract_in[25:3]) & round_up;

    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [22:0] s1_mant;
    logic        s1_carry;
    logic        s1_inexact;
    logic        s1_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= 8'd0;
            s1_mant    <= 23'd0;
            s1_carry   <= 1'b0;
            s1_inexact <= 1'b0;
            s1_zero    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= sign_in;
                s1_exp     <= exp_in;
                s1_mant    <= mant_rnd;
                s1_carry   <= carry_rnd;
                s1_inexact <= |fract_in[2:0];
                s1_zero    <= (fract_in == 27'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: exponent fix-up, special cases, pack
    // ------------------------------------------------------------------
    logic [8:0]  exp_eff;
    logic [31:0] pack_res;
    logic        pack_ovf;
    logic        pack_unf;
    logic        pack_inx;

    // 9-bit so that a carry from exponent 255 (or 254) is seen as overflow.
    assign exp_eff = {1'b0, s1_exp} + {8'd0, s1_carry};

    always_comb begin
        pack_res = 32'h0000_0000;
        pack_ovf = 1'b0;
        pack_unf = 1'b0;
        pack_inx = 1'b0;
        if (s1_zero) begin
            // Exact zero packs as +0 regardless of sign (x - x under RNE).
            pack_res = 32'h0000_0000;
        end else if (exp_eff > 9'(BIAS_MAX)) begin
            pack_res = {s1_sign, 8'hFF, 23'h0};
            pack_ovf = 1'b1;
            pack_inx = 1'b1;
        end else if (exp_eff == 9'd0) begin
            // No denormals: anything landing at exponent 0 flushes to signed zero.
            pack_res = {s1_sign, 31'h0};
            pack_unf = 1'b1;
            pack_inx = 1'b1;
        end else begin
            pack_res = {s1_sign, exp_eff[7:0], s1_mant};
            pack_inx = s1_inexact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid       <= 1'b0;
            result         <= 32'h0000_0000;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result         <= pack_res;
                flag_overflow  <= pack_ovf;
                flag_underflow <= pack_unf;
                flag_inexact   <= pack_inx;
            end
        end
    end

endmodule
